// File: rtl/intc_pkg.sv
// Shared interrupt-controller definitions: FSM encodings, default constants and
// a width helper used by both intc_top and irq_responder.
package intc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK     = 2'd2,
    ST_SERVICE = 2'd3
  } irq_state_e;

  localparam int ADDR_W_DEF      = 32;
  localparam int ACK_TIMEOUT_DEF = 16;
  localparam int SPUR_W_DEF      = 8;

  // Bits needed to count 0 .. max_val-1.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/irq_responder_if.sv
// CPU/interrupt-controller side bundle of the IRQ responder. The master drives
// requests and retirement info; the slave (responder) drives trap control.
interface irq_responder_if #(
  parameter int ADDR_W = 32,
  parameter int SPUR_W = 8
);

  logic              irq;
  logic [ADDR_W-1:0] isr_addr;
  logic              int_en;
  logic              instr_boundary;
  logic [ADDR_W-1:0] next_pc;
  logic              mret;

  logic              iack;
  logic              take_trap;
  logic [ADDR_W-1:0] trap_pc;
  logic              take_ret;
  logic [ADDR_W-1:0] epc;
  logic              in_isr;
  logic              irq_timeout;
  logic [SPUR_W-1:0] spur_cnt;

  modport master (
    output irq, isr_addr, int_en, instr_boundary, next_pc, mret,
    input  iack, take_trap, trap_pc, take_ret, epc, in_isr, irq_timeout, spur_cnt
  );

  modport slave (
    input  irq, isr_addr, int_en, instr_boundary, next_pc, mret,
    output iack, take_trap, trap_pc, take_ret, epc, in_isr, irq_timeout, spur_cnt
  );

endinterface

// File: rtl/irq_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/irq_responder.sv
// Single-level interrupt responder: waits for an instruction boundary, traps to
// the ISR vector, acknowledges the controller and returns on mret.
module irq_responder
  import intc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int SPUR_W      = SPUR_W_DEF
) (
  input logic           clk,
  input logic           rst,
  irq_responder_if.slave bus
);

  localparam int            TO_W    = cnt_width(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  irq_state_e        state, state_nxt;
  logic              accept, retire, spur_inc, to_hit;
  logic [TO_W-1:0]   ack_cnt;
  logic [SPUR_W-1:0] spur_cnt;
  logic              take_trap_q, take_ret_q, irq_timeout_q;
  logic [ADDR_W-1:0] trap_pc_q, epc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // irq is ignored in ACK/SERVICE except as the acknowledge-release signal.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    retire    = 1'b0;
    spur_inc  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.irq && bus.int_en) state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (!bus.irq) begin
          spur_inc  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (bus.instr_boundary) begin
          accept    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.irq) begin
          state_nxt = ST_SERVICE;
        end else if (ack_cnt == TO_LAST) begin
          to_hit    = 1'b1;
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.mret && bus.instr_boundary) begin
          retire    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  sat_counter #(.W(SPUR_W)) u_spur_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (spur_inc),
    .cnt (spur_cnt)
  );

  // Held at zero outside ACK so it reads 0 on the entry cycle.
  sat_counter #(.W(TO_W)) u_ack_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_ACK),
    .inc (state == ST_ACK),
    .cnt (ack_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      take_trap_q   <= 1'b0;
      take_ret_q    <= 1'b0;
      irq_timeout_q <= 1'b0;
      trap_pc_q     <= '0;
      epc_q         <= '0;
    end else begin
      take_trap_q <= accept;
      take_ret_q  <= retire;
      if (to_hit) irq_timeout_q <= 1'b1;
      if (accept) begin
        trap_pc_q <= bus.isr_addr;
        epc_q     <= bus.next_pc;
      end
    end
  end

  // Redirect pulses are registered and coincide with the state they lead into.
  assign bus.iack        = (state == ST_ACK);
  assign bus.in_isr      = (state == ST_ACK) || (state == ST_SERVICE) || take_ret_q;
  assign bus.take_trap   = take_trap_q;
  assign bus.take_ret    = take_ret_q;
  assign bus.trap_pc     = trap_pc_q;
  assign bus.epc         = epc_q;
  assign bus.irq_timeout = irq_timeout_q;
  assign bus.spur_cnt    = spur_cnt;

endmodule

// File: tb/tb_irq_responder.sv
// Directed bench for irq_responder: a behavioural model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_irq_responder;
  import intc_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int ACK_TIMEOUT = 16;
  localparam int SPUR_W      = 8;
  localparam int SPUR_MAX    = (1 << SPUR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  irq_responder_if #(.ADDR_W(ADDR_W), .SPUR_W(SPUR_W)) bus ();

  irq_responder #(
    .ADDR_W      (ADDR_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .SPUR_W      (SPUR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a request is "armed" once seen with int_en, taken at the
  // next boundary, acknowledged until irq drops or times out, then serviced.
  bit          m_armed, m_acking, m_serving, m_timeout, m_trap, m_ret;
  int          m_age, m_spur;
  logic [31:0] m_trap_pc, m_epc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_armed = 0; m_acking = 0; m_serving = 0; m_timeout = 0;
      m_trap = 0; m_ret = 0; m_age = 0; m_spur = 0;
      m_trap_pc = '0; m_epc = '0;
    end else begin
      m_trap = 0;
      m_ret  = 0;
      if (m_serving) begin
        if (bus.mret && bus.instr_boundary) begin
          m_serving = 0;
          m_ret     = 1;
        end
      end else if (m_acking) begin
        if (!bus.irq) begin
          m_acking = 0; m_serving = 1;
        end else if (m_age == ACK_TIMEOUT - 1) begin
          m_acking = 0; m_serving = 1; m_timeout = 1;
        end else begin
          m_age++;
        end
      end else if (m_armed) begin
        if (!bus.irq) begin
          m_armed = 0;
          if (m_spur < SPUR_MAX) m_spur++;
        end else if (bus.instr_boundary) begin
          m_armed = 0; m_acking = 1; m_age = 0; m_trap = 1;
          m_trap_pc = bus.isr_addr;
          m_epc     = bus.next_pc;
        end
      end else if (bus.irq && bus.int_en) begin
        m_armed = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("iack",        64'(bus.iack),        64'(m_acking));
      check("take_trap",   64'(bus.take_trap),   64'(m_trap));
      check("take_ret",    64'(bus.take_ret),    64'(m_ret));
      check("both_pulses", 64'(bus.take_trap && bus.take_ret), 64'd0);
      check("in_isr",      64'(bus.in_isr),      64'(m_acking || m_serving || m_ret));
      check("trap_pc",     64'(bus.trap_pc),     64'(m_trap_pc));
      check("epc",         64'(bus.epc),         64'(m_epc));
      check("irq_timeout", 64'(bus.irq_timeout), 64'(m_timeout));
      check("spur_cnt",    64'(bus.spur_cnt),    64'(m_spur));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_iack;

  initial begin
    bus.irq = 0; bus.isr_addr = '0; bus.int_en = 0;
    bus.instr_boundary = 0; bus.next_pc = '0; bus.mret = 0;
    #1 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_iack",    64'(bus.iack), 64'd0);
    check("rst_in_isr",  64'(bus.in_isr), 64'd0);
    check("rst_trap_pc", 64'(bus.trap_pc), 64'd0);
    check("rst_epc",     64'(bus.epc), 64'd0);
    check("rst_spur",    64'(bus.spur_cnt), 64'd0);
    tick(); tick();
    rst = 1'b0;

    // Basic trap: take_trap two edges after irq rises.
    bus.irq = 1; bus.int_en = 1; bus.instr_boundary = 1;
    bus.isr_addr = 32'h100; bus.next_pc = 32'h40;
    tick();
    check("t1_no_trap_c1", 64'(bus.take_trap), 64'd0);
    tick();
    check("t1_take_trap", 64'(bus.take_trap), 64'd1);
    check("t1_trap_pc",   64'(bus.trap_pc), 64'h100);
    check("t1_epc",       64'(bus.epc), 64'h40);
    check("t1_iack",      64'(bus.iack), 64'd1);
    bus.next_pc = 32'h44;
    tick(); tick(); tick();
    check("t1_iack_held", 64'(bus.iack), 64'd1);
    check("t1_epc_held",  64'(bus.epc), 64'h40);
    bus.irq = 0;
    tick();
    check("t1_iack_drop", 64'(bus.iack), 64'd0);
    check("t1_in_isr",    64'(bus.in_isr), 64'd1);

    // mret without a boundary does nothing.
    bus.mret = 1; bus.instr_boundary = 0;
    tick();
    check("mret_nobnd", 64'(bus.take_ret), 64'd0);

    // Return with a new irq pending: trap follows two cycles after take_ret.
    bus.irq = 1; bus.int_en = 1; bus.instr_boundary = 1;
    bus.isr_addr = 32'h200; bus.next_pc = 32'h40;
    tick();
    check("ret_take_ret", 64'(bus.take_ret), 64'd1);
    check("ret_epc",      64'(bus.epc), 64'h40);
    check("ret_no_trap",  64'(bus.take_trap), 64'd0);
    bus.mret = 0; bus.next_pc = 32'h80;
    tick();
    check("ret_trap_p1", 64'(bus.take_trap), 64'd0);
    tick();
    check("ret_trap_p2", 64'(bus.take_trap), 64'd1);
    check("ret_trap_pc", 64'(bus.trap_pc), 64'h200);
    check("ret_new_epc", 64'(bus.epc), 64'h80);

    // irq stuck high: iack for ACK_TIMEOUT cycles, then SERVICE with the flag set.
    n_iack = (bus.iack === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.iack === 1'b1) n_iack++;
      else break;
    end
    check("to_iack_len", 64'(n_iack), 64'd16);
    check("to_flag",     64'(bus.irq_timeout), 64'd1);
    check("to_service",  64'(bus.in_isr), 64'd1);
    tick();
    check("to_no_nest",  64'(bus.take_trap), 64'd0);
    bus.irq = 0; bus.mret = 1;
    tick();
    check("to_ret", 64'(bus.take_ret), 64'd1);
    bus.mret = 0;
    tick();
    check("to_idle_in_isr", 64'(bus.in_isr), 64'd0);

    // Reset in the middle of ACK abandons the interrupt at once.
    bus.irq = 1; bus.isr_addr = 32'h300; bus.next_pc = 32'hC0;
    tick(); tick();
    check("rs_trap", 64'(bus.take_trap), 64'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rs_iack_async",   64'(bus.iack), 64'd0);
    check("rs_in_isr_async", 64'(bus.in_isr), 64'd0);
    check("rs_timeout_clr",  64'(bus.irq_timeout), 64'd0);
    check("rs_epc_clr",      64'(bus.epc), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rs_new_p1", 64'(bus.take_trap), 64'd0);
    check("rs_no_ret", 64'(bus.take_ret), 64'd0);
    tick();
    check("rs_new_trap", 64'(bus.take_trap), 64'd1);
    check("rs_new_epc",  64'(bus.epc), 64'hC0);
    bus.irq = 0;
    tick();
    bus.mret = 1;
    tick();
    check("rs_ret", 64'(bus.take_ret), 64'd1);
    bus.mret = 0;
    tick();

    // Disabled interrupts are held off until int_en rises.
    bus.int_en = 0; bus.irq = 1; bus.isr_addr = 32'h400;
    tick(); tick(); tick();
    check("en_hold_trap", 64'(bus.take_trap), 64'd0);
    check("en_hold_iack", 64'(bus.iack), 64'd0);
    bus.int_en = 1;
    tick();
    check("en_p1", 64'(bus.take_trap), 64'd0);
    tick();
    check("en_trap",    64'(bus.take_trap), 64'd1);
    check("en_trap_pc", 64'(bus.trap_pc), 64'h400);
    bus.irq = 0;
    tick();
    bus.mret = 1;
    tick();
    bus.mret = 0;
    tick();

    // Spurious one-cycle pulses without a boundary saturate the counter.
    bus.instr_boundary = 0; bus.int_en = 1;
    for (int i = 0; i < 300; i++) begin
      bus.irq = 1;
      tick();
      bus.irq = 0;
      tick();
      if (i == 0) check("spur_first", 64'(bus.spur_cnt), 64'd1);
      if (i == 1) check("spur_second", 64'(bus.spur_cnt), 64'd2);
    end
    check("spur_sat",     64'(bus.spur_cnt), 64'd255);
    check("spur_no_trap", 64'(bus.in_isr), 64'd0);
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
